// File: rtl/transpad_pkg.sv
// Shared types and default widths for the transpad request router and its FIFOs.
package transpad_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;
  localparam int OUTS_DEF   = 4;

  // Encoding matches the generator's spm bit.
  typedef enum logic {
    SRC_MM  = 1'b0,
    SRC_SPM = 1'b1
  } src_t;

endpackage

// File: rtl/transpad_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read data; DEPTH must be a power of two >= 2.
module transpad_sync_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_i);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop_i);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push_i && full_o));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop_i && empty_o));

endmodule

// File: rtl/transpad_req_router.sv
// Steers generator addresses to scratchpad SRAM or main memory and returns read data
// in accept order, with outstanding requests bounded by a credit count.
module transpad_req_router
  import transpad_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int OUTS   = OUTS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              act,
  input  logic              spm,
  output logic              rdy,
  output logic              spm_en,
  output logic [ADDR_W-1:0] spm_addr,
  input  logic [DATA_W-1:0] spm_rdata,
  output logic              mm_req,
  output logic [ADDR_W-1:0] mm_addr,
  input  logic              mm_gnt,
  input  logic              mm_rvalid,
  input  logic [DATA_W-1:0] mm_rdata,
  output logic              dout_valid,
  output logic [DATA_W-1:0] dout_data,
  output logic              dout_spm,
  input  logic              dout_ready,
  output logic              err
);

  localparam int CNT_W = $clog2(OUTS) + 1;

  logic [CNT_W-1:0]  credits_q, credits_d;
  logic [CNT_W-1:0]  mm_pend_q, mm_pend_d;
  logic              spm_en_q, spm_cap_q;
  logic [ADDR_W-1:0] spm_addr_q, spm_addr_d;
  logic              mm_req_q, mm_req_d;
  logic [ADDR_W-1:0] mm_addr_q, mm_addr_d;
  logic              err_q, err_d;

  logic              accept, grant, mm_push, mm_stray, pop;
  logic              order_head, order_full, order_empty;
  logic              spm_full, spm_empty, mm_full, mm_empty;
  logic [DATA_W-1:0] spm_head, mm_head;
  src_t              head_src;
  logic              head_ready;

  // rdy is forced low while reset is held so every output reads 0 during reset.
  assign rdy      = !rst && (credits_q < CNT_W'(OUTS)) && (!mm_req_q || mm_gnt);
  assign accept   = act && rdy;
  assign grant    = mm_req_q && mm_gnt;
  assign mm_push  = mm_rvalid && (mm_pend_q != '0);
  assign mm_stray = mm_rvalid && (mm_pend_q == '0);

  assign head_src   = src_t'(order_head);
  assign head_ready = (head_src == SRC_SPM) ? !spm_empty : !mm_empty;
  assign dout_valid = !order_empty && head_ready;
  assign pop        = dout_valid && dout_ready;
  assign dout_data  = !dout_valid ? '0 : ((head_src == SRC_SPM) ? spm_head : mm_head);
  assign dout_spm   = dout_valid && (head_src == SRC_SPM);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    credits_d  = credits_q + CNT_W'(accept) - CNT_W'(pop);
    mm_pend_d  = mm_pend_q + CNT_W'(grant) - CNT_W'(mm_push);
    spm_addr_d = spm_addr_q;
    mm_req_d   = mm_req_q;
    mm_addr_d  = mm_addr_q;
    err_d      = err_q || mm_stray;
    if (accept && spm) spm_addr_d = addr;
    if (accept && !spm) begin
      mm_req_d  = 1'b1;
      mm_addr_d = addr;
    end else if (grant) begin
      mm_req_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q  <= '0;
      mm_pend_q  <= '0;
      spm_en_q   <= 1'b0;
      spm_cap_q  <= 1'b0;
      spm_addr_q <= '0;
      mm_req_q   <= 1'b0;
      mm_addr_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      mm_pend_q  <= mm_pend_d;
      spm_en_q   <= accept && spm;
      spm_cap_q  <= spm_en_q;
      spm_addr_q <= spm_addr_d;
      mm_req_q   <= mm_req_d;
      mm_addr_q  <= mm_addr_d;
      err_q      <= err_d;
    end
  end

  assign spm_en   = spm_en_q;
  assign spm_addr = spm_addr_q;
  assign mm_req   = mm_req_q;
  assign mm_addr  = mm_addr_q;
  assign err      = err_q;

  transpad_sync_fifo #(.WIDTH(1), .DEPTH(OUTS)) u_order_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .wdata_i (spm),
    .pop_i   (pop),
    .rdata_o (order_head),
    .full_o  (order_full),
    .empty_o (order_empty)
  );

  transpad_sync_fifo #(.WIDTH(DATA_W), .DEPTH(OUTS)) u_spm_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (spm_cap_q),
    .wdata_i (spm_rdata),
    .pop_i   (pop && (head_src == SRC_SPM)),
    .rdata_o (spm_head),
    .full_o  (spm_full),
    .empty_o (spm_empty)
  );

  transpad_sync_fifo #(.WIDTH(DATA_W), .DEPTH(OUTS)) u_mm_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (mm_push),
    .wdata_i (mm_rdata),
    .pop_i   (pop && (head_src == SRC_MM)),
    .rdata_o (mm_head),
    .full_o  (mm_full),
    .empty_o (mm_empty)
  );

  // The order FIFO holds exactly the outstanding credits; data FIFOs can never outgrow it.
  a_credits_track: assert property (@(posedge clk) disable iff (rst)
    order_full == (credits_q == CNT_W'(OUTS)));
  a_spm_bounded: assert property (@(posedge clk) disable iff (rst) !(spm_full && !order_full));
  a_mm_bounded:  assert property (@(posedge clk) disable iff (rst) !(mm_full && !order_full));

endmodule

// File: tb/tb_transpad_req_router.sv
// Directed-vector bench for transpad_req_router with a one-cycle SRAM model returning addr+0x100.
module tb_transpad_req_router;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = '0;
  logic        act = 1'b0;
  logic        spm = 1'b0;
  logic        rdy;
  logic        spm_en;
  logic [15:0] spm_addr;
  logic [31:0] spm_rdata;
  logic        mm_req;
  logic [15:0] mm_addr;
  logic        mm_gnt = 1'b0;
  logic        mm_rvalid = 1'b0;
  logic [31:0] mm_rdata = '0;
  logic        dout_valid;
  logic [31:0] dout_data;
  logic        dout_spm;
  logic        dout_ready = 1'b0;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] sram_q = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (spm_en) sram_q <= 32'(spm_addr) + 32'h100;
  end
  assign spm_rdata = sram_q;

  transpad_req_router dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .act        (act),
    .spm        (spm),
    .rdy        (rdy),
    .spm_en     (spm_en),
    .spm_addr   (spm_addr),
    .spm_rdata  (spm_rdata),
    .mm_req     (mm_req),
    .mm_addr    (mm_addr),
    .mm_gnt     (mm_gnt),
    .mm_rvalid  (mm_rvalid),
    .mm_rdata   (mm_rdata),
    .dout_valid (dout_valid),
    .dout_data  (dout_data),
    .dout_spm   (dout_spm),
    .dout_ready (dout_ready),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    act       = 1'b0;
    spm       = 1'b0;
    addr      = '0;
    mm_gnt    = 1'b0;
    mm_rvalid = 1'b0;
    mm_rdata  = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"},    rdy,        0);
    check({tag, "_spm_en"}, spm_en,     0);
    check({tag, "_mm_req"}, mm_req,     0);
    check({tag, "_dv"},     dout_valid, 0);
    check({tag, "_data"},   dout_data,  0);
    check({tag, "_dspm"},   dout_spm,   0);
    check({tag, "_err"},    err,        0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    dout_ready = 1'b0;
    #1;
    check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // SPM stream: spm_en cycles 1-3, dout 0x110..0x112 at cycles 3-5
    dout_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      tick();
      act  = (c < 3);
      spm  = 1'b1;
      addr = 16'(16'h0010 + c);
      #1;
      if (c < 3) check("t1_rdy", rdy, 1);
      check("t1_spm_en", spm_en, (c >= 1 && c <= 3));
      if (c >= 1 && c <= 3) check("t1_spm_addr", spm_addr, 32'h10 + c - 1);
      check("t1_dv", dout_valid, (c >= 3 && c <= 5));
      if (c >= 3 && c <= 5) begin
        check("t1_data", dout_data, 32'h110 + c - 3);
        check("t1_dspm", dout_spm, 1);
      end
    end

    // MM stall: request held 5 cycles, grant in cycle 6, data 0xCAFE in cycle 8
    for (int c = 0; c < 11; c++) begin
      tick();
      idle();
      dout_ready = 1'b1;
      if (c == 0) begin
        act = 1'b1; spm = 1'b0; addr = 16'h2000;
      end
      mm_gnt = (c == 6);
      if (c == 8) begin
        mm_rvalid = 1'b1; mm_rdata = 32'hCAFE;
      end
      #1;
      if (c == 0) check("t2_rdy0", rdy, 1);
      if (c >= 1 && c <= 5) begin
        check("t2_req", mm_req, 1);
        check("t2_addr", mm_addr, 32'h2000);
        check("t2_rdy_stall", rdy, 0);
      end
      if (c == 6) check("t2_rdy_gnt", rdy, 1);
      if (c == 7) check("t2_req_drop", mm_req, 0);
      if (c <= 8) check("t2_dv_idle", dout_valid, 0);
      if (c == 9) begin
        check("t2_dv", dout_valid, 1);
        check("t2_data", dout_data, 32'hCAFE);
        check("t2_dspm", dout_spm, 0);
      end
      if (c == 10) check("t2_dv_end", dout_valid, 0);
    end

    // Ordering: MM 0x0100 then SPM 0x0200; SPM result waits for MM data in cycle 11
    for (int c = 0; c < 15; c++) begin
      tick();
      idle();
      dout_ready = 1'b1;
      if (c == 0) begin
        act = 1'b1; spm = 1'b0; addr = 16'h0100;
      end
      if (c == 1) begin
        act = 1'b1; spm = 1'b1; addr = 16'h0200;
      end
      mm_gnt = (c == 1);
      if (c == 11) begin
        mm_rvalid = 1'b1; mm_rdata = 32'hAAAA0100;
      end
      #1;
      if (c == 1) check("t3_rdy_gnt", rdy, 1);
      if (c == 2) begin
        check("t3_req_drop", mm_req, 0);
        check("t3_spm_en", spm_en, 1);
        check("t3_spm_addr", spm_addr, 32'h200);
      end
      if (c >= 2 && c <= 11) check("t3_dv_wait", dout_valid, 0);
      if (c == 12) begin
        check("t3_dv_mm", dout_valid, 1);
        check("t3_data_mm", dout_data, 32'hAAAA0100);
        check("t3_dspm_mm", dout_spm, 0);
      end
      if (c == 13) begin
        check("t3_dv_spm", dout_valid, 1);
        check("t3_data_spm", dout_data, 32'h300);
        check("t3_dspm_spm", dout_spm, 1);
      end
      if (c == 14) check("t3_dv_end", dout_valid, 0);
    end

    // Credits: 5 SPM attempts with consumer stalled, only 4 accepted
    for (int c = 0; c < 12; c++) begin
      tick();
      idle();
      dout_ready = (c == 6 || c >= 8);
      if (c < 5) begin
        act = 1'b1; spm = 1'b1; addr = 16'(16'h0040 + c);
      end
      #1;
      if (c < 6) check("t4_rdy", rdy, (c < 4));
      if (c == 6) begin
        check("t4_rdy_prepop", rdy, 0);
        check("t4_dv", dout_valid, 1);
        check("t4_data0", dout_data, 32'h140);
      end
      if (c == 7) begin
        check("t4_rdy_freed", rdy, 1);
        check("t4_hold", dout_data, 32'h141);
      end
      if (c >= 8 && c <= 10) begin
        check("t4_dv_drain", dout_valid, 1);
        check("t4_data_drain", dout_data, 32'h141 + c - 8);
      end
      if (c == 11) check("t4_dv_end", dout_valid, 0);
    end

    // Error: stray mm_rvalid sets sticky err, no output
    for (int c = 0; c < 6; c++) begin
      tick();
      idle();
      dout_ready = 1'b1;
      if (c == 0) begin
        mm_rvalid = 1'b1; mm_rdata = 32'hDEAD;
      end
      #1;
      if (c == 0) check("t5_err_pre", err, 0);
      else begin
        check("t5_err", err, 1);
        check("t5_dv", dout_valid, 0);
      end
    end
    do_reset();

    // Reset mid-operation: MM pending, two SPM results buffered
    for (int c = 0; c < 6; c++) begin
      tick();
      idle();
      dout_ready = 1'b0;
      if (c < 2) begin
        act = 1'b1; spm = 1'b1; addr = 16'(16'h0050 + c);
      end
      if (c == 2) begin
        act = 1'b1; spm = 1'b0; addr = 16'h0060;
      end
      #1;
      if (c == 5) begin
        check("t6_req_pre", mm_req, 1);
        check("t6_dv_pre", dout_valid, 1);
        check("t6_data_pre", dout_data, 32'h150);
      end
    end
    do_reset();
    tick();
    mm_rvalid = 1'b1;
    mm_rdata  = 32'h1234;
    #1;
    check("t6_err_pre", err, 0);
    tick();
    idle();
    #1;
    check("t6_err_late", err, 1);
    check("t6_dv_late", dout_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
